// File: rtl/kia_poller.sv
// ---------------------------------------------------------------------------
// kia_poller
//   Wishbone master that sequences the keyboard interface adapter (KIA). It
//   polls the KIA status register, fetches each received scan code, retires
//   it with a pop write and buffers the codes in a small FIFO. The CPU sees a
//   two-register Wishbone slave and never talks to the KIA directly.
//
// Parameters
//   DEPTH_LOG2     FIFO depth = 2**DEPTH_LOG2 bytes
//   POLL_INTERVAL  idle cycles between status polls (>= 1)
//   ACK_TIMEOUT    cycles a master cycle may wait for M_ACK_I (>= 2)
//
// Ports
//   CLK_I, RES_I          clock (rising edge), async active-low reset
//   S_ADR_I .. S_DAT_I    CPU slave request (ADR 0 status, ADR 1 data)
//   S_ACK_O, S_DAT_O      CPU slave response, one cycle after the request
//   M_ADR_O .. M_STB_O    KIA master request, all registered
//   M_DAT_I, M_ACK_I      KIA response (ack is registered by the KIA)
//   IRQ_O                 high while the FIFO holds at least one code
// ---------------------------------------------------------------------------
module kia_poller #(
    parameter int DEPTH_LOG2    = 4,
    parameter int POLL_INTERVAL = 64,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic       CLK_I,
    input  logic       RES_I,
    input  logic       S_ADR_I,
    input  logic       S_WE_I,
    input  logic       S_CYC_I,
    input  logic       S_STB_I,
    input  logic [7:0] S_DAT_I,
    output logic       S_ACK_O,
    output logic [7:0] S_DAT_O,
    output logic       M_ADR_O,
    output logic       M_WE_O,
    output logic       M_CYC_O,
    output logic       M_STB_O,
    input  logic [7:0] M_DAT_I,
    input  logic       M_ACK_I,
    output logic       IRQ_O
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TMAX  = (POLL_INTERVAL > ACK_TIMEOUT) ? POLL_INTERVAL : ACK_TIMEOUT;
    localparam int TW    = $clog2(TMAX) + 1;

    localparam logic [TW-1:0]       POLL_LAST = TW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0]       TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    // Two GAP states so the idle cycle remembers which transaction follows.
    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_STAT   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_POP    = 3'd3;
    localparam logic [2:0] ST_GAP_D  = 3'd4;
    localparam logic [2:0] ST_GAP_P  = 3'd5;

    logic [2:0]            r_state;
    logic [TW-1:0]         r_timer;
    logic                  r_m_cyc;
    logic                  r_m_adr;
    logic                  r_m_we;
    logic [7:0]            r_hold;
    logic                  r_err;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_s_ack;
    logic [7:0]            r_s_dat;

    logic       w_empty;
    logic       w_full;
    logic       w_ack_ok;
    logic       w_timeout;
    logic       w_push;
    logic       w_s_start;
    logic       w_pop;
    logic       w_err_clr;
    logic [7:0] w_rd_dat;
    logic       w_unused;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // The KIA registers its ack, so an ack seen in the first cycle of a
    // transaction is the trailing ack of the previous one and is ignored.
    assign w_ack_ok  = r_m_cyc & M_ACK_I & (r_timer != '0);
    assign w_timeout = r_m_cyc & ~w_ack_ok & (r_timer == TMO_LAST);
    assign w_push    = (r_state == ST_POP) & w_ack_ok;

    // A CPU transaction acts only on the cycle its ack is about to rise.
    assign w_s_start = S_CYC_I & S_STB_I & ~r_s_ack;
    assign w_pop     = w_s_start & S_ADR_I & ~S_WE_I & ~w_empty;
    assign w_err_clr = w_s_start & S_WE_I & ~S_ADR_I & S_DAT_I[2];

    assign w_unused = &{1'b0, S_DAT_I[7:3], S_DAT_I[1:0]};

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it holding its old value and infer a latch.
    always_comb begin
        w_rd_dat = 8'h00;
        if (!S_WE_I) begin
            if (!S_ADR_I) begin
                w_rd_dat = {5'b0, r_err, w_full, w_empty};
            end else if (!w_empty) begin
                w_rd_dat = r_mem[r_rd_ptr];
            end
        end
    end

    // Master sequencer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            r_state <= ST_WAIT;
            r_timer <= '0;
            r_m_cyc <= 1'b0;
            r_m_adr <= 1'b0;
            r_m_we  <= 1'b0;
            r_hold  <= 8'h00;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_timer == POLL_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_STAT;
                        r_m_cyc <= 1'b1;
                        r_m_adr <= 1'b0;
                        r_m_we  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_STAT, ST_DATA, ST_POP: begin
                    if (w_ack_ok) begin
                        r_m_cyc <= 1'b0;
                        r_m_we  <= 1'b0;
                        r_timer <= '0;
                        if (r_state == ST_STAT) begin
                            // A full FIFO leaves the byte in the KIA.
                            r_state <= (!M_DAT_I[0] && !w_full) ? ST_GAP_D : ST_WAIT;
                        end else if (r_state == ST_DATA) begin
                            r_hold  <= M_DAT_I;
                            r_state <= ST_GAP_P;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_m_cyc <= 1'b0;
                        r_m_we  <= 1'b0;
                        r_timer <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_GAP_D: begin
                    r_state <= ST_DATA;
                    r_m_cyc <= 1'b1;
                    r_m_adr <= 1'b1;
                    r_m_we  <= 1'b0;
                end
                ST_GAP_P: begin
                    r_state <= ST_POP;
                    r_m_cyc <= 1'b1;
                    r_m_adr <= 1'b1;
                    r_m_we  <= 1'b1;
                end
                default: begin
                    r_state <= ST_WAIT;
                    r_timer <= '0;
                    r_m_cyc <= 1'b0;
                    r_m_we  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and an empty read is forced to 0x00 by the mux.
    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_hold;
        end
    end

    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // CPU slave and sticky error flag; a timeout wins over a same-cycle clear.
    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            r_s_ack <= 1'b0;
            r_s_dat <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_s_ack <= S_CYC_I & S_STB_I;
            if (w_s_start) r_s_dat <= w_rd_dat;
            if (w_timeout)      r_err <= 1'b1;
            else if (w_err_clr) r_err <= 1'b0;
        end
    end

    assign S_ACK_O = r_s_ack;
    assign S_DAT_O = r_s_dat;
    assign M_ADR_O = r_m_adr;
    assign M_WE_O  = r_m_we;
    assign M_CYC_O = r_m_cyc;
    assign M_STB_O = r_m_cyc;
    assign IRQ_O   = ~w_empty;

endmodule

// File: tb/tb_kia_poller.sv
// ---------------------------------------------------------------------------
// tb_kia_poller
//   Bench for kia_poller: a behavioural KIA (byte queue, registered ack with
//   random stalls) feeds the poller; a queue model of the FIFO contents gives
//   the expected CPU responses, which a negedge monitor compares whenever
//   S_ACK_O rises.
// ---------------------------------------------------------------------------
module tb_kia_poller;

    localparam int DEPTH_LOG2    = 4;
    localparam int DEPTH         = 1 << DEPTH_LOG2;
    localparam int POLL_INTERVAL = 64;
    localparam int ACK_TIMEOUT   = 15;

    logic       CLK_I = 1'b0;
    logic       RES_I = 1'b0;
    logic       S_ADR_I = 1'b0;
    logic       S_WE_I = 1'b0;
    logic       S_CYC_I = 1'b0;
    logic       S_STB_I = 1'b0;
    logic [7:0] S_DAT_I = 8'h00;
    logic       S_ACK_O;
    logic [7:0] S_DAT_O;
    logic       M_ADR_O;
    logic       M_WE_O;
    logic       M_CYC_O;
    logic       M_STB_O;
    logic [7:0] M_DAT_I;
    logic       M_ACK_I;
    logic       IRQ_O;

    kia_poller #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .POLL_INTERVAL(POLL_INTERVAL),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .CLK_I  (CLK_I),
        .RES_I  (RES_I),
        .S_ADR_I(S_ADR_I),
        .S_WE_I (S_WE_I),
        .S_CYC_I(S_CYC_I),
        .S_STB_I(S_STB_I),
        .S_DAT_I(S_DAT_I),
        .S_ACK_O(S_ACK_O),
        .S_DAT_O(S_DAT_O),
        .M_ADR_O(M_ADR_O),
        .M_WE_O (M_WE_O),
        .M_CYC_O(M_CYC_O),
        .M_STB_O(M_STB_O),
        .M_DAT_I(M_DAT_I),
        .M_ACK_I(M_ACK_I),
        .IRQ_O  (IRQ_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural KIA ----------------
    logic [7:0] kia_q[$];
    logic [7:0] model_q[$];       // expected contents of the poller FIFO
    logic       model_err = 1'b0;
    logic       kia_dead = 1'b0;
    logic       kia_block_data = 1'b0;
    logic       kia_ack;
    logic [7:0] kia_dat = 8'h01;
    logic       pend_push;
    logic [7:0] pend_byte;
    int         kia_pops = 0;

    assign M_ACK_I = kia_ack;
    assign M_DAT_I = kia_dat;

    // Ack rises one cycle after the strobe (with random stalls) and lingers one
    // cycle after the strobe drops. A pop retires the head; the poller takes
    // the byte into its FIFO on the following edge, when it sees the ack.
    always @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            kia_ack   <= 1'b0;
            pend_push <= 1'b0;
        end else begin
            if (pend_push) begin
                model_q.push_back(pend_byte);
                pend_push <= 1'b0;
            end
            if (M_CYC_O && M_STB_O && !kia_ack && !kia_dead &&
                !(kia_block_data && M_ADR_O && !M_WE_O) &&
                ($urandom_range(0, 3) != 0)) begin
                kia_ack <= 1'b1;
                if (M_WE_O && kia_q.size() != 0) begin
                    pend_byte <= kia_q.pop_front();
                    pend_push <= 1'b1;
                    kia_pops  <= kia_pops + 1;
                end
            end else begin
                kia_ack <= M_CYC_O && M_STB_O && kia_ack;
            end
        end
    end

    always @(negedge CLK_I) begin
        if (M_ADR_O) kia_dat <= (kia_q.size() != 0) ? kia_q[0] : 8'h00;
        else         kia_dat <= {7'b0, kia_q.size() == 0};
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       chk;
        logic       adr;
        logic [7:0] dat;
    } exp_t;

    exp_t exp_q[$];
    logic mon_prev = 1'b0;

    always @(negedge CLK_I) begin
        if (S_ACK_O && !mon_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 8'h01, 8'h00);
            end else begin
                if (exp_q[0].chk)
                    check(exp_q[0].adr ? "cpu_rd_data" : "cpu_rd_status", S_DAT_O, exp_q[0].dat);
                exp_q.delete(0);
            end
        end
        mon_prev <= S_ACK_O;
    end

    // ---------------- CPU helpers (called at posedge + 1) ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    task automatic cpu_xfer(input logic adr, input logic we, input logic [7:0] wdat,
                            input logic chk, input logic [7:0] exp);
        exp_t e;
        e.chk = chk;
        e.adr = adr;
        e.dat = exp;
        exp_q.push_back(e);
        S_ADR_I = adr;
        S_WE_I  = we;
        S_DAT_I = wdat;
        S_CYC_I = 1'b1;
        S_STB_I = 1'b1;
        step(1);
        S_CYC_I = 1'b0;
        S_STB_I = 1'b0;
        S_WE_I  = 1'b0;
        step(1);
    endtask

    task automatic rd_status();
        logic [7:0] e;
        e = {5'b0, model_err, model_q.size() == DEPTH, model_q.size() == 0};
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, e);
    endtask

    task automatic rd_data_model();
        logic [7:0] e;
        e = 8'h00;
        if (model_q.size() != 0) e = model_q.pop_front();
        cpu_xfer(1'b1, 1'b0, 8'h00, 1'b1, e);
    endtask

    task automatic rd_data_const(input logic [7:0] e);
        if (model_q.size() != 0) void'(model_q.pop_front());
        cpu_xfer(1'b1, 1'b0, 8'h00, 1'b1, e);
    endtask

    task automatic wait_fill(input int n, input int budget);
        int k;
        k = 0;
        while (model_q.size() != n && k < budget) begin
            step(1);
            k++;
        end
        check("fifo_fill_level", 8'(model_q.size()), 8'(n));
    endtask

    initial begin
        repeat (80000) @(posedge CLK_I);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int n;
        int base;
        int r;

        // reset state
        step(2);
        check("reset_outputs", {S_ACK_O, M_ADR_O, M_WE_O, M_CYC_O, M_STB_O, IRQ_O, 2'b00}, 8'h00);
        check("reset_sdat", S_DAT_O, 8'h00);
        RES_I = 1'b1;
        step(2);
        rd_status();

        // single code
        base = kia_pops;
        kia_q.push_back(8'h1C);
        wait_fill(1, 400);
        check("pop_write_seen", 8'(kia_pops - base), 8'h01);
        check("irq_set", {7'b0, IRQ_O}, 8'h01);
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        rd_data_const(8'h1C);
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
        check("irq_clear", {7'b0, IRQ_O}, 8'h00);

        // fill to full, 17th stays in the KIA, then wrap
        for (int i = 1; i <= DEPTH + 1; i++) kia_q.push_back(8'(i));
        wait_fill(DEPTH, 4000);
        step(3 * POLL_INTERVAL);
        check("backpressure_left", 8'(kia_q.size()), 8'h01);
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
        rd_data_const(8'h01);
        wait_fill(DEPTH, 600);
        check("kia_drained", 8'(kia_q.size()), 8'h00);
        for (int i = 2; i <= DEPTH + 1; i++) rd_data_const(8'(i));
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);

        // ack timeout
        kia_dead = 1'b1;
        k = 0;
        while (M_CYC_O && k < 200) begin step(1); k++; end
        while (!M_CYC_O && k < 400) begin step(1); k++; end
        n = 0;
        while (M_CYC_O && n < 100) begin n++; step(1); end
        check("timeout_cycles", 8'(n), 8'(ACK_TIMEOUT));
        kia_dead  = 1'b0;
        model_err = 1'b1;
        rd_status();
        cpu_xfer(1'b0, 1'b1, 8'h04, 1'b0, 8'h00);
        model_err = 1'b0;
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);

        // push and CPU pop on the same edge with three codes stored
        for (int i = 0; i < 3; i++) kia_q.push_back(8'(8'h30 + i));
        wait_fill(3, 1500);
        base = kia_pops;
        kia_q.push_back(8'h33);
        k = 0;
        while (kia_pops == base && k < 500) begin step(1); k++; end
        check("simul_pop_seen", 8'(kia_pops - base), 8'h01);
        rd_data_const(8'h30);
        check("simul_count", 8'(model_q.size()), 8'h03);
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        rd_data_const(8'h31);
        rd_data_const(8'h32);
        rd_data_const(8'h33);
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);

        // randomised traffic against the queue model
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                if (kia_q.size() < 4) kia_q.push_back(8'($urandom_range(0, 255)));
            end else if (r <= 5) begin
                rd_data_model();
            end else if (r == 6) begin
                rd_status();
            end else begin
                step($urandom_range(1, 20));
            end
        end
        k = 0;
        while (kia_q.size() != 0 && k < 3000) begin step(1); k++; end
        check("random_kia_drained", 8'(kia_q.size()), 8'h00);
        step(5);
        while (model_q.size() != 0) rd_data_model();
        rd_status();

        // reset in the middle of a DATA read
        kia_block_data = 1'b1;
        kia_q.push_back(8'hA5);
        k = 0;
        while (!(M_CYC_O && M_ADR_O && !M_WE_O) && k < 400) begin step(1); k++; end
        check("reached_data", {7'b0, M_CYC_O & M_ADR_O & ~M_WE_O}, 8'h01);
        #2;
        RES_I = 1'b0;
        #1;
        check("async_reset_outputs", {S_ACK_O, M_ADR_O, M_WE_O, M_CYC_O, M_STB_O, IRQ_O, 2'b00}, 8'h00);
        model_q.delete();
        model_err = 1'b0;
        step(2);
        RES_I = 1'b1;
        check("byte_kept_in_kia", 8'(kia_q.size()), 8'h01);
        cpu_xfer(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
        kia_block_data = 1'b0;
        wait_fill(1, 400);
        rd_data_const(8'hA5);
        rd_status();

        step(3);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
